// File: rtl/data_synchronizer.sv
// Multi-flop bus synchronizer: only the valid qualifier crosses through a flop chain; its rising edge loads the bus once.
// Optional macro DATA_SYNC_BUS_CHECK_EN adds a sticky bus_change_error flag for source-protocol violations.
`timescale 1ns/1ps
module data_synchronizer #(
   parameter int STAGE_COUNT = 2,
   parameter int BUS_WIDTH   = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 asynchronous_data_valid,
   input  logic [BUS_WIDTH-1:0] asynchronous_data,
   output logic                 Q_pulse_generator,
   output logic [BUS_WIDTH-1:0] synchronous_data,
`ifdef DATA_SYNC_BUS_CHECK_EN
   output logic                 bus_change_error,
`endif
   output logic                 synchronous_data_valid
);

   logic [STAGE_COUNT-1:0] sync_r;
   logic                   last_s;
   logic                   pulse_s;

   // Last synchronizer stage and its rising-edge detect.
   always_comb begin
      last_s  = sync_r[STAGE_COUNT-1];
      pulse_s = last_s & ~Q_pulse_generator;
   end

   // Valid qualifier synchronizer chain.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_r <= {STAGE_COUNT{1'b0}};
      end else begin
         sync_r <= {sync_r[STAGE_COUNT-2:0], asynchronous_data_valid};
      end
   end

   // Edge-detect flop, one-shot data capture and strobe.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         Q_pulse_generator      <= 1'b0;
         synchronous_data_valid <= 1'b0;
         synchronous_data       <= {BUS_WIDTH{1'b0}};
      end else begin
         Q_pulse_generator      <= last_s;
         synchronous_data_valid <= pulse_s;
         if (pulse_s) begin
            synchronous_data <= asynchronous_data;
         end else begin
            synchronous_data <= synchronous_data;
         end
      end
   end

`ifdef DATA_SYNC_BUS_CHECK_EN
   function automatic logic bus_differs(input logic [BUS_WIDTH-1:0] a,
                                        input logic [BUS_WIDTH-1:0] b);
      return |(a ^ b);
   endfunction

   logic [BUS_WIDTH-1:0] data_sample_r;
   logic                 window_s;

   // Watch window: from the first sync stage seeing valid through the pulse cycle.
   always_comb begin
      window_s = (|sync_r) & ~Q_pulse_generator;
   end

   // Each new sample is compared with the previous one while the window is open; the flag is sticky.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_sample_r    <= {BUS_WIDTH{1'b0}};
         bus_change_error <= 1'b0;
      end else begin
         data_sample_r <= asynchronous_data;
         if (window_s && bus_differs(asynchronous_data, data_sample_r)) begin
            bus_change_error <= 1'b1;
         end else begin
            bus_change_error <= bus_change_error;
         end
      end
   end
`endif

endmodule

// File: tb/tb_data_synchronizer.sv
// Directed self-checking bench for data_synchronizer at default parameters (STAGE_COUNT=2, BUS_WIDTH=4).
`timescale 1ns/1ps
module tb_data_synchronizer;

   logic       clk;
   logic       reset;
   logic       valid;
   logic [3:0] data;
   logic       q_pg;
   logic [3:0] sdata;
   logic       svalid;
`ifdef DATA_SYNC_BUS_CHECK_EN
   logic       bus_err;
`endif

   int n_cmp;
   int n_err;

   data_synchronizer #(.STAGE_COUNT(2), .BUS_WIDTH(4)) dut (
      .clk                     (clk),
      .reset                   (reset),
      .asynchronous_data_valid (valid),
      .asynchronous_data       (data),
      .Q_pulse_generator       (q_pg),
      .synchronous_data        (sdata),
`ifdef DATA_SYNC_BUS_CHECK_EN
      .bus_change_error        (bus_err),
`endif
      .synchronous_data_valid  (svalid)
   );

   initial clk = 1'b0;
   always #6 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      int strobes;
      int lat;
      logic found;
      n_cmp = 0;
      n_err = 0;

      // T1 reset
      reset = 1'b0;
      valid = 1'b0;
      data  = 4'h0;
      #20;
      check("t1_rst_valid", 32'(svalid), 32'd0);
      check("t1_rst_data",  32'(sdata),  32'd0);
      check("t1_rst_q",     32'(q_pg),   32'd0);
      tick();
      tick();
      check("t1_rst_hold_valid", 32'(svalid), 32'd0);
      reset = 1'b1;
      repeat (3) tick();
      check("t1_rel_valid", 32'(svalid), 32'd0);
      check("t1_rel_data",  32'(sdata),  32'd0);
      check("t1_rel_q",     32'(q_pg),   32'd0);

      // T2 single transfer
      data  = 4'b1010;
      valid = 1'b1;
      tick();
      check("t2_e1_valid", 32'(svalid), 32'd0);
      tick();
      check("t2_e2_valid", 32'(svalid), 32'd0);
      check("t2_e2_data",  32'(sdata),  32'd0);
      tick();
      check("t2_e3_valid", 32'(svalid), 32'd1);
      check("t2_e3_data",  32'(sdata),  32'hA);
      check("t2_e3_q",     32'(q_pg),   32'd1);
      tick();
      check("t2_e4_valid", 32'(svalid), 32'd0);
      check("t2_e4_data",  32'(sdata),  32'hA);
      valid = 1'b0;
      repeat (5) tick();

      // T3 sweep of all codes
      for (int code = 0; code < 16; code++) begin
         data  = 4'(code);
         valid = 1'b1;
         found = 1'b0;
         lat   = 0;
         for (int k = 1; k <= 8 && !found; k++) begin
            tick();
            if (svalid) begin
               found = 1'b1;
               lat   = k;
            end
         end
         check("t3_latency", 32'(lat),   32'd3);
         check("t3_data",    32'(sdata), 32'(code));
         tick();
         check("t3_one_strobe", 32'(svalid), 32'd0);
         valid = 1'b0;
         repeat (5) tick();
      end

      // T4 valid held high for 20 cycles
      data    = 4'h7;
      valid   = 1'b1;
      strobes = 0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         strobes += int'(svalid);
         check("t4_q_high", 32'(q_pg), (k >= 3) ? 32'd1 : 32'd0);
      end
      check("t4_strobes", 32'(strobes), 32'd1);
      check("t4_data",    32'(sdata),   32'h7);
      valid = 1'b0;
      tick();
      check("t4_fall_e1_q", 32'(q_pg), 32'd1);
      tick();
      check("t4_fall_e2_q", 32'(q_pg), 32'd1);
      tick();
      check("t4_fall_e3_q", 32'(q_pg), 32'd0);
      check("t4_fall_no_strobe", 32'(svalid), 32'd0);
      repeat (3) tick();

      // T5 reset mid-transfer
      data  = 4'h5;
      valid = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      check("t5_rst_valid", 32'(svalid), 32'd0);
      check("t5_rst_data",  32'(sdata),  32'd0);
      check("t5_rst_q",     32'(q_pg),   32'd0);
      tick();
      reset = 1'b1;
      tick();
      check("t5_e1_valid", 32'(svalid), 32'd0);
      tick();
      check("t5_e2_valid", 32'(svalid), 32'd0);
      tick();
      check("t5_e3_valid", 32'(svalid), 32'd1);
      check("t5_e3_data",  32'(sdata),  32'h5);
      tick();
      check("t5_e4_valid", 32'(svalid), 32'd0);

`ifdef DATA_SYNC_BUS_CHECK_EN
      // T6 bus change detection
      check("t6_clean", 32'(bus_err), 32'd0);
      valid = 1'b0;
      repeat (5) tick();
      data  = 4'h3;
      valid = 1'b1;
      tick();
      data = 4'hC;
      tick();
      check("t6_set", 32'(bus_err), 32'd1);
      repeat (3) tick();
      valid = 1'b0;
      repeat (5) tick();
      check("t6_sticky", 32'(bus_err), 32'd1);
      reset = 1'b0;
      #1;
      check("t6_rst_clear", 32'(bus_err), 32'd0);
      tick();
      reset = 1'b1;
      tick();
      check("t6_rel_clear", 32'(bus_err), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
